fir_sample_window: RTL and testbench

- Upstream feeder for the floating-point FIR MAC stage.
- Holds the last NTAPS IEEE-754 single-precision input samples in a circular buffer.
- For each accepted sample, streams the window newest-to-oldest, one sample per `next` request from the MAC.
- Asserts `stop` while the oldest tap is presented, so the MAC can finish and publish its sum.

---
 rtl/fir_sample_window.sv | 174 +++++++++++++++++
 tb/tb_fir_sample_window.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_window.sv
// Sample window feeder for the floating-point FIR MAC: keeps the last NTAPS
// samples and streams them newest-to-oldest. Optional sticky `overrun` flag: FIR_WIN_OVERRUN_EN.
module fir_sample_window #(
    parameter int NTAPS = 146,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        next,
    output logic [31:0] out,
    output logic        stop,
    output logic        frame_start,
`ifdef FIR_WIN_OVERRUN_EN
    output logic        overrun,
`endif
    output logic        busy
);

    localparam logic [AW-1:0] LAST     = AW'(NTAPS - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(NTAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    // Where the current tap comes from: the just-accepted sample, the RAM
    // read register, or zero padding for taps older than the fill level.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYPASS,
        SRC_RAM
    } src_t;

    state_t          state, state_nxt;
    src_t            src;
    logic [AW-1:0]   wp, rd, k;
    logic [AW:0]     cnt;
    logic            next_d;
    logic [31:0]     byp_q, ram_q;
    logic [31:0]     mem [0:NTAPS-1];

    logic            accept, advance, step, last_tap, tap_live;
    logic [AW-1:0]   wp_inc, rd_dn, k_inc;

    assign last_tap = (k == LAST);
    assign wp_inc   = (wp == LAST) ? '0 : wp + AW'(1);
    assign rd_dn    = (rd == '0) ? LAST : rd - AW'(1);
    assign k_inc    = k + AW'(1);
    assign tap_live = ({1'b0, k_inc} < cnt);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so
        // no path through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b1;
        busy      = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        step      = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                accept = in_valid;
                if (in_valid) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready = 1'b0;
                busy     = 1'b1;
                // Edge-detect so a held-high request advances only once.
                advance  = next & ~next_d;
                if (advance) begin
                    if (last_tap) begin
                        state_nxt = S_DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, counters and tap source selection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wp          <= '0;
            rd          <= '0;
            k           <= '0;
            cnt         <= '0;
            next_d      <= 1'b0;
            frame_start <= 1'b0;
            src         <= SRC_ZERO;
            byp_q       <= '0;
        end else begin
            next_d      <= next;
            frame_start <= accept;
            if (accept) begin
                wp    <= wp_inc;
                rd    <= wp;
                k     <= '0;
                cnt   <= (cnt == CNT_FULL) ? cnt : cnt + (AW + 1)'(1);
                src   <= SRC_BYPASS;
                byp_q <= in_data;
            end else if (step) begin
                k   <= k_inc;
                rd  <= rd_dn;
                src <= tap_live ? SRC_RAM : SRC_ZERO;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer: one write port, one registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset so it maps onto block RAM; stale
        // contents are never shown because cnt gates every read.
        if (accept) begin
            mem[wp] <= in_data;
        end
        if (step) begin
            ram_q <= mem[rd_dn];
        end
    end

    always_comb begin
        out = 32'h0;
        case (src)
            SRC_BYPASS: out = byp_q;
            SRC_RAM:    out = ram_q;
            default:    out = 32'h0;
        endcase
    end

    assign stop = (state != S_IDLE) && last_tap;

`ifdef FIR_WIN_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_window.sv
// Directed scoreboard bench for fir_sample_window with a 4-tap window.
// Build with FIR_WIN_OVERRUN_EN defined to also check the sticky overrun flag.
module tb_fir_sample_window;

    localparam int NTAPS = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        next;
    logic [31:0] out;
    logic        stop;
    logic        frame_start;
    logic        busy;
`ifdef FIR_WIN_OVERRUN_EN
    logic        overrun;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] hist [$];
    logic [31:0] exp_q [$];
    logic [31:0] last_exp;

    fir_sample_window #(.NTAPS(NTAPS), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .next        (next),
        .out         (out),
        .stop        (stop),
        .frame_start (frame_start),
`ifdef FIR_WIN_OVERRUN_EN
        .overrun     (overrun),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: newest-first history, window pushed to the scoreboard.
    task automatic model_push(input logic [31:0] d);
        hist.push_front(d);
        if (hist.size() > NTAPS) void'(hist.pop_back());
        for (int i = 0; i < NTAPS; i++)
            exp_q.push_back((i < hist.size()) ? hist[i] : 32'h0);
    endtask

    task automatic check_tap(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        last_exp = e;
        check(tag, out, e);
    endtask

    task automatic pulse_next();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
    endtask

    task automatic accept_window(input logic [31:0] d);
        check("ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        model_push(d);
        @(negedge clk);
        in_valid = 1'b0;
        check_tap("tap0");
        check("frame_start_pulse", {31'b0, frame_start}, 32'd1);
        check("busy_stream", {31'b0, busy}, 32'd1);
        check("ready_low_stream", {31'b0, in_ready}, 32'd0);
        check("stop_tap0", {31'b0, stop}, 32'd0);
        @(negedge clk);
        check("frame_start_one_cycle", {31'b0, frame_start}, 32'd0);
    endtask

    task automatic stream_rest(input int from_k);
        for (int i = from_k + 1; i < NTAPS; i++) begin
            pulse_next();
            check_tap($sformatf("tap%0d", i));
            check($sformatf("stop_tap%0d", i), {31'b0, stop}, {31'b0, (i == NTAPS - 1)});
        end
        pulse_next();
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_ready", {31'b0, in_ready}, 32'd1);
        check("done_stop_held", {31'b0, stop}, 32'd1);
        check("done_out_held", out, last_exp);
    endtask

    initial begin
        logic [31:0] held;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        next     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_stop", {31'b0, stop}, 32'd0);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef FIR_WIN_OVERRUN_EN
        check("rst_overrun", {31'b0, overrun}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Cold fill: one sample then zero padding.
        accept_window(32'h3F80_0000);
        stream_rest(0);

        // Fill and wrap: the fifth window overwrites 1.0.
        accept_window(32'h4000_0000); stream_rest(0);
        accept_window(32'h4040_0000); stream_rest(0);
        accept_window(32'h4080_0000); stream_rest(0);
        accept_window(32'h40A0_0000); stream_rest(0);

        // Held next: exactly one advance over five cycles.
        accept_window(32'h40C0_0000);
        next = 1'b1;
        @(negedge clk);
        check_tap("held_tap1");
        held = last_exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_no_readvance", out, held);
        end
        next = 1'b0;
        @(negedge clk);

        // Backpressure: sample offered mid-stream is dropped.
        in_valid = 1'b1;
        in_data  = 32'h4120_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_out_unchanged", out, held);
        check("bp_busy", {31'b0, busy}, 32'd1);
`ifdef FIR_WIN_OVERRUN_EN
        check("bp_overrun_set", {31'b0, overrun}, 32'd1);
`endif
        stream_rest(1);
`ifdef FIR_WIN_OVERRUN_EN
        check("overrun_sticky", {31'b0, overrun}, 32'd1);
`endif

        // Coincident accept and next edge in DONE: accept wins.
        in_valid = 1'b1;
        in_data  = 32'h40E0_0000;
        next     = 1'b1;
        model_push(32'h40E0_0000);
        @(negedge clk);
        in_valid = 1'b0;
        check_tap("coin_tap0");
        check("coin_stop", {31'b0, stop}, 32'd0);
        check("coin_frame_start", {31'b0, frame_start}, 32'd1);
        check("coin_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("coin_no_extra_advance", out, last_exp);
        next = 1'b0;
        @(negedge clk);
        pulse_next();
        check_tap("coin_tap1");
        pulse_next();
        check_tap("coin_tap2");

        // Reset at k=2, then a restarted cold window.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out", out, 32'h0);
        check("mid_rst_stop", {31'b0, stop}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef FIR_WIN_OVERRUN_EN
        check("mid_rst_overrun", {31'b0, overrun}, 32'd0);
`endif
        exp_q.delete();
        hist.delete();
        @(negedge clk);
        accept_window(32'h3F80_0000);
        stream_rest(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
